bcd_counter_mux: RTL and testbench

BCD_COUNTER_MUX -- requirements
Module: bcd_counter_mux

---
 rtl/bcd_counter_mux.sv | 170 +++++++++++++++++
 tb/tb_bcd_counter_mux.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mux.sv
// bcd_counter_mux: prescaled up/down BCD counter driving a time-multiplexed,
// active-low seven-segment display with optional leading-zero blanking.
module bcd_counter_mux #(
    parameter int CLK_DIV  = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4,
    parameter int LZB      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg,
    output logic                tick,
    output logic                carry
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                tick_q, tick_d;
    logic                carry_q, carry_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    logic [4*DIGITS-1:0] stepped;
    logic                ripple;
    logic [3:0]          cur_digit;
    logic                blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // Candidate count for a step: BCD +1 or -1 rippling through digits; ripple left set means every digit wrapped
    always_comb begin
        stepped = value_q;
        ripple  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                if (up) begin
                    if (value_q[4*i +: 4] >= 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (value_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else if (value_q[4*i +: 4] > 4'd9) begin
                        stepped[4*i +: 4] = 4'd9;
                        ripple = 1'b0;
                    end else begin
                        stepped[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
    end

    // Prescaler and count: clear wins over a step; a step happens when the enabled prescaler is at its last value
    always_comb begin
        presc_d = presc_q;
        value_d = value_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            value_d = '0;
        end else if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                value_d = stepped;
                tick_d  = 1'b1;
                carry_d = ripple;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Display scan timing runs free of en and clr, stepping the digit index once per slot
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            scan_d = scan_q + SW'(1);
        end
    end

    // Digit select and segment pattern for the current index, blanking zeros above the highest nonzero digit
    always_comb begin
        cur_digit = 4'd0;
        an_d      = '1;
        blank     = (LZB != 0) && (idx_q != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                cur_digit = value_q[4*i +: 4];
                an_d[i]   = 1'b0;
            end
            if ((IW'(i) >= idx_q) && (value_q[4*i +: 4] != 4'd0)) begin
                blank = 1'b0;
            end
        end
        seg_d = blank ? 8'hFF : seg_decode(cur_digit);
    end

    // Register all state; reset overrides clear, enable and any pending step
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            value_q <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            value_q <= value_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign value = value_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_counter_mux.sv
// tb_bcd_counter_mux: two counter/display configurations driven by directed
// scenarios and random stimulus, checked against an arithmetic reference model.
module tb_bcd_counter_mux;

    localparam int A_CLK_DIV  = 4;
    localparam int A_SCAN_DIV = 3;
    localparam int A_DIGITS   = 2;
    localparam int A_LZB      = 0;
    localparam int B_CLK_DIV  = 2;
    localparam int B_SCAN_DIV = 2;
    localparam int B_DIGITS   = 4;
    localparam int B_LZB      = 1;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] en;
    logic [1:0] up;
    logic [1:0] clr;

    logic [7:0]  value_a;
    logic [1:0]  an_a;
    logic [7:0]  seg_a;
    logic        tick_a;
    logic        carry_a;
    logic [15:0] value_b;
    logic [3:0]  an_b;
    logic [7:0]  seg_b;
    logic        tick_b;
    logic        carry_b;

    int errors = 0;
    int checks = 0;

    int cfg_clk_div[2]  = '{A_CLK_DIV, B_CLK_DIV};
    int cfg_scan_div[2] = '{A_SCAN_DIV, B_SCAN_DIV};
    int cfg_digits[2]   = '{A_DIGITS, B_DIGITS};
    int cfg_lzb[2]      = '{A_LZB, B_LZB};
    int seg_table[10]   = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'hF8, 'h80, 'h90};

    // Model state: the count is a plain integer modulo 10^DIGITS
    int m_cnt[2];
    int m_presc[2];
    int m_scan[2];
    int m_idx[2];
    int m_an[2];
    int m_seg[2];
    bit m_tick[2];
    bit m_carry[2];
    bit m_valid[2];

    bcd_counter_mux #(
        .CLK_DIV(A_CLK_DIV), .SCAN_DIV(A_SCAN_DIV), .DIGITS(A_DIGITS), .LZB(A_LZB)
    ) dut_a (
        .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .clr(clr[0]),
        .value(value_a), .an(an_a), .seg(seg_a), .tick(tick_a), .carry(carry_a)
    );

    bcd_counter_mux #(
        .CLK_DIV(B_CLK_DIV), .SCAN_DIV(B_SCAN_DIV), .DIGITS(B_DIGITS), .LZB(B_LZB)
    ) dut_b (
        .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .clr(clr[1]),
        .value(value_b), .an(an_b), .seg(seg_b), .tick(tick_b), .carry(carry_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_bcd(input int n, input int digits);
        int r = 0;
        for (int i = 0; i < digits; i++) r = r | (((n / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    // A digit above position 0 is blank when the whole count is below 10^position
    function automatic int model_seg(input int k, input int cnt, input int idx);
        if (cfg_lzb[k] != 0 && idx > 0 && cnt < pow10(idx)) return 'hFF;
        return seg_table[(cnt / pow10(idx)) % 10];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Random inputs for one cycle: mostly enabled, sticky direction, rare clear and reset
    task automatic apply_stimulus();
        for (int k = 0; k < 2; k++) begin
            en[k]  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) up[k] = ~up[k];
            clr[k] = ($urandom_range(0, 199) == 0);
            rst[k] = ($urandom_range(0, 499) != 0);
        end
        next_cycle();
    endtask

    // Reference model advances on every rising edge from the inputs held since the previous edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k] == 1'b0) begin
                m_cnt[k]   = 0;
                m_presc[k] = 0;
                m_scan[k]  = 0;
                m_idx[k]   = 0;
                m_an[k]    = (1 << cfg_digits[k]) - 1;
                m_seg[k]   = 'hFF;
                m_tick[k]  = 1'b0;
                m_carry[k] = 1'b0;
                m_valid[k] = 1'b1;
            end else if (m_valid[k]) begin
                m_an[k]    = ((1 << cfg_digits[k]) - 1) & ~(1 << m_idx[k]);
                m_seg[k]   = model_seg(k, m_cnt[k], m_idx[k]);
                m_tick[k]  = 1'b0;
                m_carry[k] = 1'b0;
                if (clr[k]) begin
                    m_cnt[k]   = 0;
                    m_presc[k] = 0;
                end else if (en[k]) begin
                    if (m_presc[k] == cfg_clk_div[k] - 1) begin
                        m_presc[k] = 0;
                        m_tick[k]  = 1'b1;
                        if (up[k]) begin
                            m_cnt[k] = m_cnt[k] + 1;
                            if (m_cnt[k] == pow10(cfg_digits[k])) begin
                                m_cnt[k]   = 0;
                                m_carry[k] = 1'b1;
                            end
                        end else if (m_cnt[k] == 0) begin
                            m_cnt[k]   = pow10(cfg_digits[k]) - 1;
                            m_carry[k] = 1'b1;
                        end else begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end
                    end else begin
                        m_presc[k] = m_presc[k] + 1;
                    end
                end
                if (m_scan[k] == cfg_scan_div[k] - 1) begin
                    m_scan[k] = 0;
                    m_idx[k]  = (m_idx[k] + 1) % cfg_digits[k];
                end else begin
                    m_scan[k] = m_scan[k] + 1;
                end
            end
        end
    end

    // Compare both DUTs against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (m_valid[0]) begin
            check_output("a_value", 32'(value_a), to_bcd(m_cnt[0], A_DIGITS));
            check_output("a_an", 32'(an_a), m_an[0]);
            check_output("a_seg", 32'(seg_a), m_seg[0]);
            check_output("a_tick", 32'(tick_a), 32'(m_tick[0]));
            check_output("a_carry", 32'(carry_a), 32'(m_carry[0]));
        end
        if (m_valid[1]) begin
            check_output("b_value", 32'(value_b), to_bcd(m_cnt[1], B_DIGITS));
            check_output("b_an", 32'(an_b), m_an[1]);
            check_output("b_seg", 32'(seg_b), m_seg[1]);
            check_output("b_tick", 32'(tick_b), 32'(m_tick[1]));
            check_output("b_carry", 32'(carry_b), 32'(m_carry[1]));
        end
    end

    // Directed scenarios followed by a random soak
    initial begin
        int cyc;
        int n;
        int tick_count;
        int carry_count;
        logic [3:0] prev_an;
        logic [3:0] exp_an_b[4];
        logic [7:0] exp_seg_b[4];

        rst = 2'b00;
        en  = 2'b00;
        up  = 2'b11;
        clr = 2'b00;
        repeat (3) next_cycle();

        check_output("reset_value_a", 32'(value_a), 32'h0);
        check_output("reset_an_a", 32'(an_a), 32'h3);
        check_output("reset_seg_a", 32'(seg_a), 32'hFF);
        check_output("reset_tick_a", 32'(tick_a), 32'h0);
        check_output("reset_an_b", 32'(an_b), 32'hF);
        check_output("reset_seg_b", 32'(seg_b), 32'hFF);

        // 100 up steps on A: first edge after reset shows digit 0, then a tick every 4th cycle
        rst   = 2'b11;
        en[0] = 1'b1;
        cyc = 0;
        tick_count = 0;
        carry_count = 0;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            cyc++;
            if (i == 0) begin
                check_output("release_an_a", 32'(an_a), 32'h2);
                check_output("release_seg_a", 32'(seg_a), 32'hC0);
                check_output("release_an_b", 32'(an_b), 32'hE);
                check_output("release_seg_b", 32'(seg_b), 32'hC0);
            end
            if (tick_a) begin
                tick_count++;
                check_output("tick_gap", 32'(cyc), 32'd4);
                cyc = 0;
            end
            if (carry_a) begin
                carry_count++;
                check_output("carry_value", 32'(value_a), 32'h00);
            end
        end
        check_output("tick_count", 32'(tick_count), 32'd100);
        check_output("carry_count", 32'(carry_count), 32'd1);
        check_output("wrap_value", 32'(value_a), 32'h00);

        // Down from 00 wraps to 99 with carry, the following step gives 98 without
        up[0] = 1'b0;
        repeat (4) next_cycle();
        check_output("down_wrap_value", 32'(value_a), 32'h99);
        check_output("down_wrap_carry", 32'(carry_a), 32'h1);
        repeat (4) next_cycle();
        check_output("down_next_value", 32'(value_a), 32'h98);
        check_output("down_next_carry", 32'(carry_a), 32'h0);
        check_output("down_next_tick", 32'(tick_a), 32'h1);

        // Hold with the prescaler at 2: prescaler goes 2->3, then the step on the next enabled edge
        repeat (2) next_cycle();
        en[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check_output("hold_tick", 32'(tick_a), 32'h0);
        end
        en[0] = 1'b1;
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (!tick_a && n < 10);
        check_output("resume_edges", 32'(n), 32'd2);
        check_output("resume_value", 32'(value_a), 32'h97);

        // Clear on the step edge at 41 suppresses the step and restarts the prescaler
        up[0] = 1'b1;
        n = 0;
        while ((m_cnt[0] != 41 || m_presc[0] != A_CLK_DIV - 1) && n < 1000) begin
            next_cycle();
            n++;
        end
        check_output("pre_clear_value", 32'(value_a), 32'h41);
        clr[0] = 1'b1;
        next_cycle();
        clr[0] = 1'b0;
        check_output("clear_value", 32'(value_a), 32'h00);
        check_output("clear_tick", 32'(tick_a), 32'h0);
        check_output("clear_carry", 32'(carry_a), 32'h0);
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (!tick_a && n < 10);
        check_output("clear_restart_edges", 32'(n), 32'd4);
        check_output("clear_restart_value", 32'(value_a), 32'h01);

        // B counts up to 0305 then holds while the scan shows 5, 0, 3 and a blanked leading zero
        en[1] = 1'b1;
        up[1] = 1'b1;
        n = 0;
        while (m_cnt[1] != 305 && n < 1000) begin
            next_cycle();
            n++;
        end
        en[1] = 1'b0;
        check_output("b_reach_value", 32'(value_b), 32'h0305);
        repeat (4) next_cycle();
        exp_an_b  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg_b = '{8'h92, 8'hC0, 8'hB0, 8'hFF};
        prev_an = an_b;
        n = 0;
        do begin
            next_cycle();
            n++;
            if (an_b == 4'hE && prev_an != 4'hE) break;
            prev_an = an_b;
        end while (n < 12);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 2; c++) begin
                if (s != 0 || c != 0) next_cycle();
                check_output("scan_an_b", 32'(an_b), 32'(exp_an_b[s]));
                check_output("scan_seg_b", 32'(seg_b), 32'(exp_seg_b[s]));
            end
        end

        // Reset pulse mid-slot at 57 on A: blank display, then digit 0 showing 0
        n = 0;
        while (m_cnt[0] != 57 && n < 1000) begin
            next_cycle();
            n++;
        end
        en[0] = 1'b0;
        check_output("pre_reset_value", 32'(value_a), 32'h57);
        n = 0;
        while (m_scan[0] != 1 && n < 6) begin
            next_cycle();
            n++;
        end
        rst[0] = 1'b0;
        next_cycle();
        rst[0] = 1'b1;
        check_output("pulse_an_a", 32'(an_a), 32'h3);
        check_output("pulse_seg_a", 32'(seg_a), 32'hFF);
        check_output("pulse_value_a", 32'(value_a), 32'h00);
        next_cycle();
        check_output("after_pulse_an_a", 32'(an_a), 32'h2);
        check_output("after_pulse_seg_a", 32'(seg_a), 32'hC0);
        check_output("after_pulse_value_a", 32'(value_a), 32'h00);

        // Random soak on both configurations, checked every cycle by the model
        up = 2'b10;
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus();
        end

        rst = 2'b11;
        en  = 2'b00;
        clr = 2'b00;
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
